// File: rtl/dbnc_pkg.sv
// Shared constants for the key debounce front end of the priority encoder path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dbnc_pkg;

    // Default prescaler divide: one sample tick per 1 ms at 50 MHz.
    localparam int DEF_TICK_DIV     = 50000;
    // Default number of consecutive differing ticks before a key output flips.
    localparam int DEF_STABLE_TICKS = 10;
    // Number of debounced key inputs.
    localparam int KEY_N            = 8;

endpackage

// File: rtl/debounce_bit.sv
// One key channel: 2-flop synchroniser, tick-driven stability counter, stable level flop.
// Latency: level follows a clean raw change after 2 clocks of sync plus STABLE_TICKS ticks.
// Backpressure: none; rise/fall are single-cycle registered strobes coincident with level.
module debounce_bit #(
    parameter int STABLE_TICKS = 10,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    // Count value on which the next tick commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    // Next-state: synchronise raw, then require STABLE_TICKS ticks of continuous difference.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q == level_q) begin
            // Agreement (including any bounce back) discards the partial count.
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State and strobe registers; reset drops any partial count and all strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/key_debounce8.sv
// Conditions 8 raw keys and an enable switch into clean encoder inputs plus edge strobes.
// Latency: en 2 clocks; x 2+(STABLE_TICKS-1)*TICK_DIV+1 .. 2+STABLE_TICKS*TICK_DIV clocks.
// Backpressure: none; strobes are one-cycle pulses and cannot be stalled.
module key_debounce8
    import dbnc_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_N-1:0] key_raw,
    input  logic             en_raw,
    output logic [KEY_N-1:0] x,
    output logic             en,
    output logic [KEY_N-1:0] rise,
    output logic [KEY_N-1:0] fall,
    output logic             changed
);

    // A divide of 1 still needs a 1-bit counter that simply stays at 0.
    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic          en_s1_q, en_s1_d;
    logic          en_q,    en_d;

    assign tick = (presc_q == PRESC_LAST);

    // Next-state for the sample prescaler and the enable synchroniser.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        en_s1_d = en_raw;
        en_d    = en_s1_q;
    end

    // Prescaler wraps 0..TICK_DIV-1; the enable output flop doubles as its second sync stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            en_s1_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            en_s1_q <= en_s1_d;
            en_q    <= en_d;
        end
    end

    // One independent debounce channel per key, all sharing the same tick.
    for (genvar i = 0; i < KEY_N; i++) begin : g_key
        debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (CNT_W)
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .raw   (key_raw[i]),
            .level (x[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    assign en = en_q;
    // Built only from strobe flop outputs, so it pulses in exactly the same cycle as rise/fall.
    assign changed = |(rise | fall);

endmodule

// File: tb/tb_key_debounce8.sv
// Bench for key_debounce8 with TICK_DIV=4, STABLE_TICKS=3.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_debounce8;

    localparam int TD = 4;
    localparam int ST = 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] key_raw = 8'h00;
    logic       en_raw  = 1'b0;
    logic [7:0] x, rise, fall;
    logic       en, changed;

    int n_cmp = 0;
    int n_bad = 0;

    key_debounce8 #(.TICK_DIV(TD), .STABLE_TICKS(ST), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_raw (key_raw),
        .en_raw  (en_raw),
        .x       (x),
        .en      (en),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each bit flips once its synchronised input has disagreed with the output over a
    // contiguous run of edges that contains ST sample ticks. Tick edges are those whose
    // index since reset release satisfies e % TD == TD-1.
    logic [7:0] m_x = 8'h00, m_rise = 8'h00, m_fall = 8'h00;
    logic       m_en = 1'b0, m_changed = 1'b0;
    logic [7:0] m_kq[$];
    logic       m_eq[$];
    int         m_edge = 0;
    bit         m_act[8];
    int         m_start[8];

    function automatic int ticks_in(input int a, input int b);
        return (b + 1) / TD - a / TD;
    endfunction

    initial begin
        m_kq = '{8'h00, 8'h00};
        m_eq = '{1'b0};
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_x = 8'h00; m_rise = 8'h00; m_fall = 8'h00;
                m_en = 1'b0; m_changed = 1'b0; m_edge = 0;
                m_kq = '{8'h00, 8'h00};
                m_eq = '{1'b0};
                for (int i = 0; i < 8; i++) m_act[i] = 1'b0;
            end else begin
                logic [7:0] s;
                s = m_kq.pop_front();
                m_kq.push_back(key_raw);
                m_en = m_eq.pop_front();
                m_eq.push_back(en_raw);
                m_rise = 8'h00;
                m_fall = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    if (s[i] == m_x[i]) begin
                        m_act[i] = 1'b0;
                    end else begin
                        if (!m_act[i]) begin
                            m_act[i]   = 1'b1;
                            m_start[i] = m_edge;
                        end
                        if (ticks_in(m_start[i], m_edge) == ST) begin
                            m_x[i] = s[i];
                            if (s[i]) m_rise[i] = 1'b1;
                            else      m_fall[i] = 1'b1;
                            m_act[i] = 1'b0;
                        end
                    end
                end
                m_changed = |(m_rise | m_fall);
                m_edge++;
            end
        end
    end

    // Continuous comparison of every output against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("model {x,en,rise,fall,changed}", {x, en, rise, fall, changed},
                {m_x, m_en, m_rise, m_fall, m_changed});
        end
    end

    // ---------------- helpers ----------------
    task automatic after_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; key_raw = 8'h00; en_raw = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] key;
        logic       en_in;
        int         hold;
        logic [7:0] exp_x;
        logic       exp_en;
    } vec_t;

    vec_t tbl[8];

    int hit, nrise, nchg, idx;
    bit leak;

    initial begin
        tbl[0] = '{8'hFF, 1'b1, 16, 8'hFF, 1'b1};
        tbl[1] = '{8'hA5, 1'b0, 16, 8'hA5, 1'b0};
        tbl[2] = '{8'h5A, 1'b1,  2, 8'hA5, 1'b1};  // too short to pass
        tbl[3] = '{8'hA5, 1'b1, 16, 8'hA5, 1'b1};
        tbl[4] = '{8'h5A, 1'b0, 16, 8'h5A, 1'b0};
        tbl[5] = '{8'h00, 1'b1, 16, 8'h00, 1'b1};
        tbl[6] = '{8'h81, 1'b0,  1, 8'h00, 1'b1};  // en still shows old level after 1 edge
        tbl[7] = '{8'h81, 1'b0, 16, 8'h81, 1'b0};

        // 1. reset with all inputs high
        @(posedge clk); #1;
        rst_n = 1'b0; key_raw = 8'hFF; en_raw = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset x", x, 0);
        chk("reset en", en, 0);
        chk("reset strobes", {rise, fall, changed}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) begin
            after_edge();
            chk("reset exit strobes", {rise, fall, changed}, 0);
        end

        // 2. clean press of bit 4
        do_reset();
        @(posedge clk); #1 key_raw = 8'h10;
        hit = -1; nrise = 0;
        for (int k = 1; k <= 20; k++) begin
            after_edge();
            if (rise != 0) nrise++;
            if (hit < 0 && x != 0) begin
                hit = k;
                chk("press x", x, 8'h10);
                chk("press rise", rise, 8'h10);
                chk("press fall", fall, 0);
                chk("press changed", changed, 1);
            end
        end
        chk("press edge in [11,14]", (hit >= 11 && hit <= 14), 1);
        chk("press single rise", nrise, 1);

        // 3. bounce rejection on bit 3
        do_reset();
        @(posedge clk); #1;
        leak = 1'b0; nrise = 0;
        for (int c = 0; c < 60; c++) begin
            key_raw[3] = ((c / 5) % 2 == 0);
            @(posedge clk); #1;
            if (x[3]) leak = 1'b1;
            if (rise[3]) nrise++;
        end
        chk("bounce no leak", leak, 0);
        key_raw[3] = 1'b1;
        hit = -1;
        for (int k = 1; k <= 20; k++) begin
            after_edge();
            if (rise[3]) nrise++;
            if (hit < 0 && x[3]) hit = k;
        end
        chk("bounce edge in [11,14]", (hit >= 11 && hit <= 14), 1);
        chk("bounce single rise", nrise, 1);

        // 4. simultaneous rise and fall
        do_reset();
        @(posedge clk); #1 key_raw = 8'h0F;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("simul start x", x, 8'h0F);
        @(posedge clk); #1 key_raw = 8'hF0;
        hit = -1; nchg = 0;
        for (int k = 1; k <= 20; k++) begin
            after_edge();
            if (changed) nchg++;
            if (hit < 0 && x != 8'h0F) begin
                hit = k;
                chk("simul x", x, 8'hF0);
                chk("simul rise", rise, 8'hF0);
                chk("simul fall", fall, 8'h0F);
                chk("simul changed", changed, 1);
            end
        end
        chk("simul edge in [11,14]", (hit >= 11 && hit <= 14), 1);
        chk("simul single changed", nchg, 1);

        // 5. reset mid-debounce
        do_reset();
        @(posedge clk); #1 key_raw = 8'h01;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk("midrst x", x, 0);
        hit = -1;
        for (int k = 1; k <= 20; k++) begin
            after_edge();
            if (hit < 0 && x != 0) begin
                hit = k;
                chk("midrst final x", x, 8'h01);
            end
        end
        chk("midrst edge in [11,14]", (hit >= 11 && hit <= 14), 1);

        // 6. enable path
        do_reset();
        @(posedge clk); #1 en_raw = 1'b1;
        after_edge(); chk("en after 1", en, 0);
        after_edge(); chk("en after 2", en, 1);
        @(posedge clk); #1 en_raw = 1'b0;
        @(posedge clk); #1 en_raw = 1'b1;
        @(negedge clk); chk("en glitch +1", en, 1);
        after_edge();   chk("en glitch +2", en, 0);
        after_edge();   chk("en glitch +3", en, 1);

        // table-driven level steps
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            key_raw = tbl[i].key;
            en_raw  = tbl[i].en_in;
            repeat (tbl[i].hold) @(posedge clk);
            @(negedge clk);
            chk($sformatf("table[%0d] x", i), x, tbl[i].exp_x);
            chk($sformatf("table[%0d] en", i), en, tbl[i].exp_en);
        end

        // randomized traffic, checked continuously against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 5) == 0) begin
                idx = $urandom_range(0, 7);
                key_raw[idx] = ~key_raw[idx];
            end
            if ($urandom_range(0, 3) == 0) en_raw = ~en_raw;
            if (c == 400) rst_n = 1'b0;
            if (c == 401) rst_n = 1'b1;
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
